// File: rtl/alu_mul_sequencer_if.sv
// Shared CPU types plus the pipeline/ALU-facing bundle of the multiply sequencer.
// slave = sequencer side, master = pipeline + ALU side.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
endpackage

interface alu_mul_sequencer_if;
    import cpu_types_pkg::*;

    logic   start;
    word_t  a;
    word_t  b;
    logic   busy;
    logic   done;
    word_t  result;
    logic   alu_req;
    logic   alu_gnt;
    aluop_t alu_op;
    word_t  alu_a;
    word_t  alu_b;
    word_t  alu_o;

    modport slave (
        input  start, a, b, alu_gnt, alu_o,
        output busy, done, result, alu_req, alu_op, alu_a, alu_b
    );

    modport master (
        output start, a, b, alu_gnt, alu_o,
        input  busy, done, result, alu_req, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier (low 32 bits of A*B) built on the shared single-cycle ALU.
// The ALU is borrowed through req/gnt; a withheld grant simply freezes the sequencer.
module alu_mul_sequencer
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    alu_mul_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t state_q;
    word_t  mcand_q;
    word_t  mplr_q;
    word_t  acc_q;
    word_t  result_q;
    logic   busy_q;
    logic   done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= bus.a;
                        mplr_q  <= bus.b;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        if (bus.b == '0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end else if (bus.b[0]) begin
                            state_q <= ADD;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                ADD: begin
                    if (bus.alu_gnt) begin
                        acc_q <= bus.alu_o;
                        // No multiplier bits left above bit 0: this add was the last one.
                        if ((mplr_q >> 1) == 32'd0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.alu_o;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.alu_gnt) begin
                        mcand_q <= bus.alu_o;
                        mplr_q  <= mplr_q >> 1;
                        state_q <= mplr_q[1] ? ADD : SHIFT;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ALU drive depends only on registered state, keeping alu_o out of any loop.
    logic   alu_req;
    aluop_t alu_op;
    word_t  alu_a;
    word_t  alu_b;

    always_comb begin
        alu_req = 1'b0;
        alu_op  = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        unique case (state_q)
            ADD: begin
                alu_req = 1'b1;
                alu_op  = ALU_ADD;
                alu_a   = acc_q;
                alu_b   = mcand_q;
            end
            SHIFT: begin
                alu_req = 1'b1;
                alu_op  = ALU_SLL;
                alu_a   = mcand_q;
                alu_b   = 32'd1;
            end
            default: ;
        endcase
    end

    assign bus.alu_req = alu_req;
    assign bus.alu_op  = alu_op;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench: drivers push expected products/latencies, a negedge monitor pops on done.
module tb_alu_mul_sequencer;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_mul_sequencer_if bus();

    alu_mul_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference single-cycle ALU
    assign bus.alu_o = (bus.alu_op == ALU_ADD) ? bus.alu_a + bus.alu_b :
                       (bus.alu_op == ALU_SLL) ? bus.alu_a << bus.alu_b[4:0] : 32'd0;

    typedef struct {
        word_t res;
        int    lat;
        int    start_cyc;
        int    exp_stalls;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     stall_budget = 0;
    bit     gnt_rand = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from accepting edge to done inclusive with full grant.
    function automatic int model_lat(input word_t bv);
        int pc = 0;
        int msb = 0;
        if (bv == 32'd0) return 1;
        for (int i = 0; i < 32; i++)
            if (bv[i]) begin
                pc++;
                msb = i;
            end
        return pc + msb + 1;
    endfunction

    // Grant driver: optional directed stall on ADD, otherwise random or always granted.
    initial begin
        bus.alu_gnt = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            if (stall_budget > 0 && bus.alu_req && bus.alu_op == ALU_ADD) begin
                bus.alu_gnt = 1'b0;
                stall_budget--;
            end else if (gnt_rand) begin
                bus.alu_gnt = ($urandom_range(3) != 0);
            end else begin
                bus.alu_gnt = 1'b1;
            end
        end
    end

    // Monitor
    word_t  held = 32'd0;
    int     stalls = 0;
    logic   prev_stall = 1'b0;
    aluop_t p_op = ALU_ADD;
    word_t  p_a = 32'd0;
    word_t  p_b = 32'd0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                held = 32'd0;
                stalls = 0;
                prev_stall = 1'b0;
                continue;
            end
            chk("busy", 32'(bus.busy), 32'(q.size() != 0));
            if (!bus.busy || bus.done) begin
                chk("alu_req_idle", 32'(bus.alu_req), 32'd0);
                chk("alu_op_idle", 32'(bus.alu_op), 32'(ALU_ADD));
                chk("alu_a_idle", bus.alu_a, 32'd0);
                chk("alu_b_idle", bus.alu_b, 32'd0);
            end
            if (prev_stall) begin
                chk("stall_op", 32'(bus.alu_op), 32'(p_op));
                chk("stall_a", bus.alu_a, p_a);
                chk("stall_b", bus.alu_b, p_b);
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat + stalls));
                    if (e.exp_stalls >= 0) chk("stalls", 32'(stalls), 32'(e.exp_stalls));
                    held = e.res;
                    stalls = 0;
                end
            end else begin
                chk("result_hold", bus.result, held);
            end
            prev_stall = bus.alu_req && !bus.alu_gnt;
            if (prev_stall) stalls++;
            p_op = bus.alu_op;
            p_a  = bus.alu_a;
            p_b  = bus.alu_b;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_mul(input word_t av, input word_t bv, input int xst);
        exp_t e;
        int t = 0;
        while (bus.busy && t < 300) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        e.res = av * bv;
        e.lat = model_lat(bv);
        e.start_cyc = cyc + 1;
        e.exp_stalls = xst;
        @(posedge CLK); #1;
        q.push_back(e);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || bus.busy) && t < 300) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int t;
        word_t ra, rb;
        bus.start = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_alu_req", 32'(bus.alu_req), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        do_mul(32'd7, 32'd6, 0);               drain();
        do_mul(32'h1234, 32'd0, 0);            drain();
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0); drain();
        do_mul(32'hFFFFFFFD, 32'd5, 0);        drain();

        stall_budget = 3;
        do_mul(32'd7, 32'd6, 3);               drain();

        // start while busy is ignored; start during DONE is ignored, then taken in IDLE.
        do_mul(32'd5, 32'd5, 0);
        bus.start = 1'b1;
        bus.a = 32'd2;
        bus.b = 32'd3;
        t = 0;
        while (!bus.done && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("done_timeout", 32'(bus.done), 32'd1);
        bus.a = 32'd4;
        bus.b = 32'd6;
        e.res = 32'd24;
        e.lat = model_lat(32'd6);
        e.start_cyc = cyc + 2;
        e.exp_stalls = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        q.push_back(e);
        bus.start = 1'b0;
        drain();

        // Reset mid-operation abandons the multiply without a done pulse.
        do_mul(32'd9, 32'hFF, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        q.delete();
        RST = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        do_mul(32'd3, 32'd4, 0);               drain();

        gnt_rand = 1'b1;
        repeat (40) begin
            ra = $urandom;
            case ($urandom_range(4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(255);
                2:       rb = 32'd0;
                3:       rb = 32'hFFFFFFFF;
                default: rb = 32'd1 << $urandom_range(31);
            endcase
            do_mul(ra, rb, -1);
        end
        drain();
        repeat (2) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
